// File: rtl/fetch_unit_pkg.sv
// Shared LC-3b fetch types: word type, fetch FSM encoding, IF/ID entry and NOP.
package lc3b_types;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {FETCH, WAIT_BUF, DRAIN} fetch_state_e;

  typedef struct packed {
    lc3b_word ir;
    lc3b_word pc;
    logic     valid;
  } ifid_t;

  localparam lc3b_word NOP = 16'h0000;

  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit and imem.
interface fetch_unit_if;
  import lc3b_types::*;
  logic     imem_read;
  lc3b_word imem_address;
  lc3b_word imem_rdata;
  logic     imem_resp;

  modport master (output imem_read, imem_address, input imem_rdata, imem_resp);
  modport slave  (input imem_read, imem_address, output imem_rdata, imem_resp);
endinterface

// File: rtl/fetch_unit_buffer.sv
// 1-entry fetch buffer: holds a returned word while IF/ID is stalled.
module fetch_buffer
  import lc3b_types::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  logic  i_clear,
  input  ifid_t i_ent,
  output ifid_t o_ent
);
  ifid_t r_ent;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ent <= '{ir: NOP, pc: '0, valid: 1'b0};
    else if (i_clear) r_ent.valid <= 1'b0;
    else if (i_load)  r_ent <= i_ent;
  end

  assign o_ent = r_ent;
endmodule

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch: owns PC and imem handshake, drives the IF/ID latch.
module fetch_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000,
  parameter lc3b_word NOP_IR   = NOP
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  imem,
  input  logic          flow_ID_EX,
  input  logic          gen_bubble,
  input  logic          squash_ID,
  input  lc3b_word      pc_target,
  output lc3b_word      IF_ID_ir,
  output lc3b_word      IF_ID_pc,
  output logic          IF_ID_valid
);
  fetch_state_e r_state, w_state_nxt;
  lc3b_word     r_pc, r_drain_addr, w_pc_next, w_addr;
  ifid_t        r_ifid, w_fb_in, w_fb_out;
  logic         w_adv, w_read, w_resp, w_fb_load, w_fb_clear;

  localparam ifid_t IFID_NOP = '{ir: NOP_IR, pc: 16'h0000, valid: 1'b0};

  assign w_adv     = flow_ID_EX && !gen_bubble;
  assign w_resp    = imem.imem_resp;
  assign w_pc_next = pc_inc(r_pc);
  assign w_fb_in   = '{ir: imem.imem_rdata, pc: w_pc_next, valid: 1'b1};

  assign w_fb_load  = !squash_ID && (r_state == FETCH) && w_resp && !w_adv;
  assign w_fb_clear = squash_ID || ((r_state == WAIT_BUF) && w_adv);

  fetch_buffer u_fbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_fb_load),
    .i_clear (w_fb_clear),
    .i_ent   (w_fb_in),
    .o_ent   (w_fb_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  // A request that is already on the bus must complete, so squash mid-read drains it.
  always_comb begin
    w_state_nxt = r_state;
    if (squash_ID) begin
      w_state_nxt = (w_read && !w_resp) ? DRAIN : FETCH;
    end else begin
      case (r_state)
        FETCH:    if (w_resp && !w_adv) w_state_nxt = WAIT_BUF;
        WAIT_BUF: if (w_adv)            w_state_nxt = FETCH;
        DRAIN:    if (w_resp)           w_state_nxt = FETCH;
        default:                        w_state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    w_read = 1'b0;
    w_addr = r_pc;
    case (r_state)
      FETCH: w_read = 1'b1;
      DRAIN: begin
        w_read = 1'b1;
        w_addr = r_drain_addr;
      end
      default: ;
    endcase
  end

  assign imem.imem_read    = w_read;
  assign imem.imem_address = w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_ifid       <= IFID_NOP;
    end else if (squash_ID) begin
      r_pc         <= pc_target & 16'hFFFE;
      r_drain_addr <= w_addr;
      r_ifid       <= IFID_NOP;
    end else begin
      if ((r_state == FETCH) && w_resp) r_pc <= w_pc_next;
      if (w_adv) begin
        case (r_state)
          FETCH:    r_ifid <= w_resp ? w_fb_in : IFID_NOP;
          WAIT_BUF: r_ifid <= w_fb_out;
          default:  r_ifid <= IFID_NOP;
        endcase
      end
    end
  end

  assign IF_ID_ir    = r_ifid.ir;
  assign IF_ID_pc    = r_ifid.pc;
  assign IF_ID_valid = r_ifid.valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-wait imem model (rdata = addr ^ 16'h5A00).
module tb_fetch_unit;
  import lc3b_types::*;

  logic     clk, rst_n, flow, bubble, squash;
  lc3b_word target, ifid_ir, ifid_pc;
  logic     ifid_vld;
  int       ws, wcnt;
  int       n_chk, n_pass;

  fetch_unit_if u_if();

  fetch_unit #(.RESET_PC(16'h0000), .NOP_IR(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (u_if),
    .flow_ID_EX  (flow),
    .gen_bubble  (bubble),
    .squash_ID   (squash),
    .pc_target   (target),
    .IF_ID_ir    (ifid_ir),
    .IF_ID_pc    (ifid_pc),
    .IF_ID_valid (ifid_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign u_if.imem_resp  = u_if.imem_read && (wcnt >= ws);
  assign u_if.imem_rdata = u_if.imem_address ^ 16'h5A00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wcnt <= 0;
    else if (u_if.imem_read && !u_if.imem_resp) wcnt <= wcnt + 1;
    else                                        wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; flow = 1'b1; bubble = 1'b0; squash = 1'b0; target = '0; ws = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir",  ifid_ir,  16'h0000);
    chk("rst_pc",  ifid_pc,  16'h0000);
    chk("rst_vld", ifid_vld, 1'b0);
    rst_n = 1'b1;
    chk("rd0",   u_if.imem_read,    1'b1);
    chk("addr0", u_if.imem_address, 16'h0000);

    // zero-wait streaming
    step; chk("s1_ir", ifid_ir, 16'h5A00); chk("s1_pc", ifid_pc, 16'h0002);
          chk("s1_vld", ifid_vld, 1'b1);  chk("s1_addr", u_if.imem_address, 16'h0002);
    step; chk("s2_ir", ifid_ir, 16'h5A02); chk("s2_pc", ifid_pc, 16'h0004);
    step; chk("s3_ir", ifid_ir, 16'h5A04); chk("s3_pc", ifid_pc, 16'h0006);
          chk("s3_addr", u_if.imem_address, 16'h0006);

    // bubble holds IF/ID while the response lands in the buffer
    bubble = 1'b1;
    step; chk("bub_ir", ifid_ir, 16'h5A04); chk("bub_pc", ifid_pc, 16'h0006);
          chk("bub_rd", u_if.imem_read, 1'b0);
    step; chk("bub2_ir", ifid_ir, 16'h5A04); chk("bub2_rd", u_if.imem_read, 1'b0);
    bubble = 1'b0;
    step; chk("rel_ir", ifid_ir, 16'h5A06); chk("rel_pc", ifid_pc, 16'h0008);
          chk("rel_addr", u_if.imem_address, 16'h0008);
    step; chk("nxt_ir", ifid_ir, 16'h5A08); chk("nxt_pc", ifid_pc, 16'h000A);

    // squash with a 3-wait read to 0x0006 in flight
    squash = 1'b1; target = 16'h0006;
    step; squash = 1'b0; ws = 3;
    chk("sq0_addr", u_if.imem_address, 16'h0006);
    step;
    squash = 1'b1; target = 16'h0041;
    step; squash = 1'b0;
    chk("sqd_vld", ifid_vld, 1'b0); chk("sqd_ir", ifid_ir, 16'h0000);
    chk("sqd_rd", u_if.imem_read, 1'b1); chk("sqd_addr", u_if.imem_address, 16'h0006);
    step; chk("dr_addr", u_if.imem_address, 16'h0006); chk("dr_resp", u_if.imem_resp, 1'b1);
    step; chk("tgt_addr", u_if.imem_address, 16'h0040); chk("tgt_vld", ifid_vld, 1'b0);
    repeat (3) step;
    chk("tgt_resp", u_if.imem_resp, 1'b1);
    step; chk("tgt_ir", ifid_ir, 16'h5A40); chk("tgt_pc", ifid_pc, 16'h0042);

    // squash coincident with resp and bubble
    ws = 0; bubble = 1'b1; squash = 1'b1; target = 16'h0100;
    step; squash = 1'b0; bubble = 1'b0;
    chk("co_vld", ifid_vld, 1'b0); chk("co_ir", ifid_ir, 16'h0000);
    chk("co_addr", u_if.imem_address, 16'h0100);
    step; chk("co2_ir", ifid_ir, 16'h5B00); chk("co2_pc", ifid_pc, 16'h0102);

    // PC wrap
    squash = 1'b1; target = 16'hFFFE;
    step; squash = 1'b0;
    chk("wr_addr0", u_if.imem_address, 16'hFFFE);
    step; chk("wr_ir", ifid_ir, 16'hA5FE); chk("wr_pc", ifid_pc, 16'h0000);
          chk("wr_addr", u_if.imem_address, 16'h0000);
    step; chk("wr2_ir", ifid_ir, 16'h5A00); chk("wr2_pc", ifid_pc, 16'h0002);

    // async reset while draining
    ws = 3; squash = 1'b1; target = 16'h0080;
    step; squash = 1'b0;
    chk("rm_addr", u_if.imem_address, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", ifid_vld, 1'b0); chk("ar_ir", ifid_ir, 16'h0000);
    chk("ar_pc", ifid_pc, 16'h0000); chk("ar_addr", u_if.imem_address, 16'h0000);
    chk("ar_rd", u_if.imem_read, 1'b1);
    ws = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    step; chk("pr_ir", ifid_ir, 16'h5A00); chk("pr_pc", ifid_pc, 16'h0002);
          chk("pr_vld", ifid_vld, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
